// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl: sweeps a ring-oscillator bank, one at a time,
// counting synchronised rising edges over a fixed clk window.
// Optional macro RO_MEAS_CONTINUOUS_EN: restart the next sweep
// straight from the last handshake while start is held high.
module ro_measure_ctrl #(
  parameter int NUM_RO = 4,
  parameter int SETTLE = 8,
  parameter int WINDOW = 1024,
  parameter int CNT_W  = 16,
  localparam int IDX_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_RO-1:0] ro_q,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  output logic              done
);

  localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    SET_END  = TW'(SETTLE - 1);
  localparam logic [TW-1:0]    WIN_END  = TW'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             prev_q, prev_d;
  logic             done_q, done_d;

  logic sel;
  logic rise;
  logic last;

  assign sel  = ro_q[idx_q];
  assign rise = sel & ~prev_q;
  assign last = (idx_q == IDX_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: index, timer, counter, edge history, done
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      tmr_q  <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      prev_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      tmr_q  <= tmr_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      prev_q <= prev_d;
      done_q <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_q == SET_END) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (tmr_q == WIN_END) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (res_ready) begin
          if (!last) begin
            state_d = S_SETTLE;
          end else begin
`ifdef RO_MEAS_CONTINUOUS_EN
            state_d = start ? S_SETTLE : S_IDLE;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: timing, edge counting with saturation
  always_comb begin
    idx_d  = idx_q;
    tmr_d  = tmr_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    prev_d = prev_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        tmr_d = '0;
      end
      S_SETTLE: begin
        // history reloaded so the window never opens on a false edge
        prev_d = sel;
        if (tmr_q == SET_END) begin
          tmr_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COUNT: begin
        prev_d = sel;
        if (rise) begin
          if (cnt_q == CNT_MAX) sat_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end
        if (tmr_q == WIN_END) tmr_d = '0;
        else                  tmr_d = tmr_q + 1'b1;
      end
      S_REPORT: begin
        if (res_ready) begin
          tmr_d = '0;
          if (last) begin
            idx_d  = '0;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: one-hot enable only while settling or counting
  always_comb begin
    ro_en = '0;
    if (state_q == S_SETTLE || state_q == S_COUNT)
      ro_en[idx_q] = 1'b1;
    busy      = (state_q != S_IDLE);
    res_valid = (state_q == S_REPORT);
    res_idx   = idx_q;
    res_count = cnt_q;
    res_sat   = sat_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb_ro_measure_ctrl: scoreboard bench for ro_measure_ctrl.
// Second small instance exercises counter saturation.
module tb_ro_measure_ctrl;

  localparam int NRO = 4;
  localparam int ST  = 8;
  localparam int WIN = 100;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NRO-1:0] ro_q;
  logic [NRO-1:0] ro_en;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [1:0]     res_idx;
  logic [15:0]    res_count;
  logic           res_sat;
  logic           done;

  logic       start2;
  logic [1:0] ro_q2;
  logic [1:0] ro_en2;
  logic       busy2;
  logic       valid2;
  logic       ready2;
  logic [0:0] idx2;
  logic [3:0] count2;
  logic       sat2;
  logic       done2;

  ro_measure_ctrl #(
    .NUM_RO(NRO), .SETTLE(ST), .WINDOW(WIN), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ro_q(ro_q), .ro_en(ro_en), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_count(res_count),
    .res_sat(res_sat), .done(done)
  );

  ro_measure_ctrl #(
    .NUM_RO(2), .SETTLE(ST), .WINDOW(WIN), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start2),
    .ro_q(ro_q2), .ro_en(ro_en2), .busy(busy2),
    .res_valid(valid2), .res_ready(ready2),
    .res_idx(idx2), .res_count(count2),
    .res_sat(sat2), .done(done2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int cyc    = 0;

  // oscillator models: ro_q[k] toggles every k+1 cycles
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NRO; k++)
      ro_q[k] = (mode == 1) ? 1'b1 : (((cyc / (k + 1)) % 2) != 0);
    ro_q2 = {2{cyc[0]}};
  end

  typedef struct {
    int idx;
    int lo;
    int hi;
    bit sat;
  } exp_t;

  exp_t sb[$];

  // scoreboard monitor: pop and compare on each handshake
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result idx=%0d count=%0d required none",
                 res_idx, res_count);
      end else begin
        e = sb.pop_front();
        if (int'(res_idx) !== e.idx) begin
          errors++;
          $display("FAIL res_idx got %0d required %0d", res_idx, e.idx);
        end
        checks++;
        if (int'(res_count) < e.lo || int'(res_count) > e.hi) begin
          errors++;
          $display("FAIL res_count idx%0d got %0d required %0d..%0d",
                   e.idx, res_count, e.lo, e.hi);
        end
        checks++;
        if (res_sat !== e.sat) begin
          errors++;
          $display("FAIL res_sat idx%0d got %0b required %0b",
                   e.idx, res_sat, e.sat);
        end
      end
    end
  end

  task automatic push_one(input int i, input int lo, input int hi);
    exp_t e;
    e.idx = i;
    e.lo  = lo;
    e.hi  = hi;
    e.sat = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_sweep(input bit flat);
    if (flat) begin
      for (int k = 0; k < NRO; k++) push_one(k, 0, 0);
    end else begin
      push_one(0, 50, 50);
      push_one(1, 25, 25);
      push_one(2, 16, 18);
      push_one(3, 11, 13);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    res_ready = 1'b1;
    start2    = 1'b0;
    ready2    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ro_en, busy, res_valid, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl en=%b busy=%b valid=%b done=%b required 0",
               ro_en, busy, res_valid, done);
    end
    checks++;
    if ({res_idx, res_count, res_sat} !== 19'b0) begin
      errors++;
      $display("FAIL reset_res idx=%0d count=%0d sat=%b required 0",
               res_idx, res_count, res_sat);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [3:0]  seq[$];
    logic [3:0]  last_en = '0;
    logic [15:0] got;
    int          dones = 0;
    int          multi = 0;
    mode      = 0;
    res_ready = 1'b1;
    push_sweep(1'b0);
    pulse_start();
    for (int i = 0; i < 600; i++) begin
      if (ro_en !== 4'b0 && ro_en !== last_en) begin
        seq.push_back(ro_en);
        last_en = ro_en;
      end
      if ($countones(ro_en) > 1) multi++;
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL sweep_done_count got %0d required 1", dones);
    end
    got = (seq.size() == 4) ? {seq[0], seq[1], seq[2], seq[3]} : 16'hFFFF;
    checks++;
    if (got !== 16'h1248) begin
      errors++;
      $display("FAIL sweep_en_seq got %h required 1248", got);
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL sweep_onehot got %0d multi-hot cycles required 0", multi);
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end pending=%0d busy=%b required 0 0",
               sb.size(), busy);
    end
  endtask

  task automatic test_no_false_edge();
    bit ok;
    mode = 1;
    push_sweep(1'b1);
    pulse_start();
    wait_done(600, ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL const_high_done done=%b pending=%0d required 1 0",
               ok, sb.size());
    end
    mode = 0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    bit ok;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
        @(negedge clk);
        if (valid2 === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sat_timeout result %0d got none required valid", r);
      end else begin
        if (int'(idx2) !== r) begin
          errors++;
          $display("FAIL sat_idx got %0d required %0d", idx2, r);
        end
        checks++;
        if (count2 !== 4'd15) begin
          errors++;
          $display("FAIL sat_count got %0d required 15", count2);
        end
        checks++;
        if (sat2 !== 1'b1) begin
          errors++;
          $display("FAIL sat_flag got %b required 1", sat2);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_done got %b required 1", done2);
    end
  endtask

  task automatic test_stall();
    bit          ok = 1'b0;
    int          unstable = 0;
    int          en_on = 0;
    logic [1:0]  c_idx;
    logic [15:0] c_cnt;
    logic        c_sat;
    mode      = 0;
    res_ready = 1'b0;
    push_sweep(1'b0);
    pulse_start();
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout got no res_valid required valid");
    end
    c_idx = res_idx;
    c_cnt = res_count;
    c_sat = res_sat;
    repeat (50) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_idx !== c_idx ||
          res_count !== c_cnt || res_sat !== c_sat) unstable++;
      if (ro_en !== 4'b0 || busy !== 1'b1) en_on++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL stall_stable got %0d changed cycles required 0",
               unstable);
    end
    checks++;
    if (en_on != 0) begin
      errors++;
      $display("FAIL stall_en got %0d cycles with ro_en/busy wrong required 0",
               en_on);
    end
    checks++;
    if (c_idx !== 2'd0) begin
      errors++;
      $display("FAIL stall_idx got %0d required 0", c_idx);
    end
    res_ready = 1'b1;
    wait_done(600, ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_done done=%b pending=%0d required 1 0",
               ok, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    int spurious = 0;
    mode      = 0;
    res_ready = 1'b1;
    push_one(0, 50, 50);
    push_one(1, 25, 25);
    pulse_start();
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (ro_en === 4'b0100) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reach_idx2 got en=%b required 0100", ro_en);
    end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ro_en, busy, res_valid, done, res_idx, res_count, res_sat}
        !== 26'b0) begin
      errors++;
      $display("FAIL mid_reset_out en=%b busy=%b valid=%b cnt=%0d required 0",
               ro_en, busy, res_valid, res_count);
    end
    reset = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL mid_abort spurious=%0d pending=%0d required 0 0",
               spurious, sb.size());
    end
    push_sweep(1'b0);
    pulse_start();
    checks++;
    if (ro_en !== 4'b0001) begin
      errors++;
      $display("FAIL mid_restart_en got %b required 0001", ro_en);
    end
    wait_done(600, ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL mid_restart_done done=%b pending=%0d required 1 0",
               ok, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    mode      = 0;
    res_ready = 1'b1;
    push_sweep(1'b0);
    @(negedge clk) start = 1'b1;
    wait_done(600, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_first_done got none required pulse");
    end
`ifdef RO_MEAS_CONTINUOUS_EN
    checks++;
    if (busy !== 1'b1 || ro_en !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_cont busy=%b en=%b required 1 0001", busy, ro_en);
    end
    push_sweep(1'b0);
    start = 1'b0;
`else
    checks++;
    if (busy !== 1'b0 || ro_en !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_idle busy=%b en=%b required 0 0000", busy, ro_en);
    end
    push_sweep(1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ro_en !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_restart busy=%b en=%b required 1 0001", busy, ro_en);
    end
    start = 1'b0;
`endif
    wait_done(600, ok);
    checks++;
    if (!ok || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_second done=%b busy=%b pending=%0d required 1 0 0",
               ok, busy, sb.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    res_ready = 1'b1;
    start2    = 1'b0;
    ready2    = 1'b1;
    test_reset();
    test_sweep();
    test_no_false_edge();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
